// File: rtl/sequential_divider_param.sv
// Sequential restoring divider producing a Q_W-bit unsigned fraction floor(N*2^Q_W/D),
// saturating at full scale, with busy/done handshake, divide-by-zero flag and optional rounding.
module sequential_divider_param #(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned Q_W           = 8,
    parameter int unsigned ROUND_NEAREST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_now,
    input  logic [DATA_W-1:0] divisor,
    input  logic [DATA_W-1:0] oscillator_out,
    output logic [Q_W-1:0]    q_out,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero
);

    localparam int unsigned REM_W = DATA_W + 1;
    localparam int unsigned CNT_W = $clog2(Q_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

    state_t             state_q, state_nxt;
    logic [DATA_W-1:0]  d_q, d_nxt;
    logic [DATA_W-1:0]  n_q, n_nxt;
    logic [REM_W-1:0]   rem_q, rem_nxt;
    logic [Q_W-1:0]     quo_q, quo_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [Q_W-1:0]     q_out_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               dz_nxt;

    logic [REM_W-1:0]   rem_shift;
    logic [REM_W-1:0]   d_ext;
    logic               bit_set;
    logic [REM_W:0]     rem_dbl;
    logic               round_up;
    logic [Q_W-1:0]     quo_rounded;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            d_q         <= '0;
            n_q         <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            q_out       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            d_q         <= d_nxt;
            n_q         <= n_nxt;
            rem_q       <= rem_nxt;
            quo_q       <= quo_nxt;
            cnt_q       <= cnt_nxt;
            q_out       <= q_out_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            div_by_zero <= dz_nxt;
        end
    end

    // Next-state, iteration step and result selection
    always_comb begin
        state_nxt = state_q;
        d_nxt     = d_q;
        n_nxt     = n_q;
        rem_nxt   = rem_q;
        quo_nxt   = quo_q;
        cnt_nxt   = cnt_q;
        q_out_nxt = q_out;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        dz_nxt    = div_by_zero;

        d_ext     = REM_W'(d_q);
        rem_shift = {rem_q[DATA_W-1:0], 1'b0};
        bit_set   = (rem_shift >= d_ext);

        // Round half-up: remainder at least half the divisor
        rem_dbl     = {rem_q, 1'b0};
        round_up    = (ROUND_NEAREST != 0) && (rem_dbl >= (REM_W + 1)'(d_q));
        quo_rounded = quo_q;
        if (round_up && !(&quo_q)) begin
            quo_rounded = quo_q + Q_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (sample_now) begin
                    d_nxt     = divisor;
                    n_nxt     = oscillator_out;
                    rem_nxt   = REM_W'(oscillator_out);
                    quo_nxt   = '0;
                    cnt_nxt   = '0;
                    dz_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                rem_nxt = bit_set ? (rem_shift - d_ext) : rem_shift;
                quo_nxt = {quo_q[Q_W-2:0], bit_set};
                cnt_nxt = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(Q_W - 1)) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
                if (d_q == '0) begin
                    q_out_nxt = '1;
                    dz_nxt    = 1'b1;
                end else if (n_q >= d_q) begin
                    q_out_nxt = '1;
                end else begin
                    q_out_nxt = quo_rounded;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sequential_divider_param.sv
// Directed bench: a truncating and a rounding divider driven in parallel from a vector table,
// plus hand-written sequences for reset, busy re-pulse, mid-CALC abort and back-to-back operation.
module tb_sequential_divider_param;

    logic        tb_clk;
    logic        rst;
    logic        sample_now;
    logic [15:0] divisor;
    logic [15:0] oscillator_out;
    logic [7:0]  q_out, q_out_r;
    logic        busy, busy_r;
    logic        done, done_r;
    logic        div_by_zero, div_by_zero_r;

    int n_checks = 0;
    int n_fail   = 0;

    sequential_divider_param #(.DATA_W(16), .Q_W(8), .ROUND_NEAREST(0)) dut (
        .clk(tb_clk), .rst(rst), .sample_now(sample_now), .divisor(divisor),
        .oscillator_out(oscillator_out), .q_out(q_out), .busy(busy), .done(done),
        .div_by_zero(div_by_zero)
    );

    sequential_divider_param #(.DATA_W(16), .Q_W(8), .ROUND_NEAREST(1)) dut_r (
        .clk(tb_clk), .rst(rst), .sample_now(sample_now), .divisor(divisor),
        .oscillator_out(oscillator_out), .q_out(q_out_r), .busy(busy_r), .done(done_r),
        .div_by_zero(div_by_zero_r)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    typedef struct {
        logic [15:0] d;
        logic [15:0] n;
        logic [7:0]  q;
        logic [7:0]  q_r;
        logic        dz;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Accept one division; return cycles from accept to done and whether busy ever dropped early
    task automatic do_div(input logic [15:0] d, input logic [15:0] n, output int lat, output logic gap);
        @(negedge tb_clk);
        divisor        = d;
        oscillator_out = n;
        sample_now     = 1'b1;
        @(posedge tb_clk);
        #1;
        sample_now = 1'b0;
        lat = 0;
        gap = !(busy && busy_r);
        while (!done && lat < 50) begin
            @(posedge tb_clk);
            #1;
            lat++;
            if (!done && !(busy && busy_r)) gap = 1'b1;
        end
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge tb_clk);
            #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        int          lat;
        logic        gap;
        int          cnt;
        int          t0, t1, t2, cyc;

        vecs[0]  = '{16'd22727, 16'd22000, 8'd247, 8'd248, 1'b0};
        vecs[1]  = '{16'd22727, 16'd22256, 8'd250, 8'd251, 1'b0};
        vecs[2]  = '{16'd22727, 16'd22727, 8'd255, 8'd255, 1'b0};
        vecs[3]  = '{16'd22727, 16'd0,     8'd0,   8'd0,   1'b0};
        vecs[4]  = '{16'd22727, 16'd30000, 8'd255, 8'd255, 1'b0};
        vecs[5]  = '{16'd0,     16'd1234,  8'd255, 8'd255, 1'b1};
        vecs[6]  = '{16'd22727, 16'd22000, 8'd247, 8'd248, 1'b0};
        vecs[7]  = '{16'd22727, 16'd22726, 8'd255, 8'd255, 1'b0};
        vecs[8]  = '{16'd3,     16'd1,     8'd85,  8'd85,  1'b0};
        vecs[9]  = '{16'd3,     16'd2,     8'd170, 8'd171, 1'b0};
        vecs[10] = '{16'd65535, 16'd65534, 8'd255, 8'd255, 1'b0};
        vecs[11] = '{16'd65535, 16'd1,     8'd0,   8'd0,   1'b0};
        vecs[12] = '{16'd2,     16'd1,     8'd128, 8'd128, 1'b0};
        vecs[13] = '{16'd0,     16'd0,     8'd255, 8'd255, 1'b1};

        rst = 1'b1;
        sample_now = 1'b0;
        divisor = '0;
        oscillator_out = '0;

        // Reset values, then held one clock after release
        repeat (2) @(posedge tb_clk);
        #1;
        check("rst_q", 32'(q_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_dz", 32'(div_by_zero), 0);
        @(negedge tb_clk);
        rst = 1'b0;
        @(posedge tb_clk);
        #1;
        check("post_rst_q", 32'(q_out), 0);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_done", 32'(done), 0);

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            do_div(vecs[i].d, vecs[i].n, lat, gap);
            check($sformatf("v%0d_latency", i), 32'(lat), 9);
            check($sformatf("v%0d_busy_gap", i), 32'(gap), 0);
            check($sformatf("v%0d_busy_at_done", i), 32'(busy), 0);
            check($sformatf("v%0d_q", i), 32'(q_out), 32'(vecs[i].q));
            check($sformatf("v%0d_q_round", i), 32'(q_out_r), 32'(vecs[i].q_r));
            check($sformatf("v%0d_dz", i), 32'(div_by_zero), 32'(vecs[i].dz));
            check($sformatf("v%0d_dz_round", i), 32'(div_by_zero_r), 32'(vecs[i].dz));
            @(posedge tb_clk);
            #1;
            check($sformatf("v%0d_done_one_cycle", i), 32'(done), 0);
        end

        // Sticky div_by_zero clears on the next accept edge; q_out holds mid-operation
        do_div(16'd0, 16'd1234, lat, gap);
        check("dz_set", 32'(div_by_zero), 1);
        @(negedge tb_clk);
        divisor = 16'd22727;
        oscillator_out = 16'd22000;
        sample_now = 1'b1;
        @(posedge tb_clk);
        #1;
        sample_now = 1'b0;
        check("dz_clear_on_accept", 32'(div_by_zero), 0);
        check("q_hold_at_accept", 32'(q_out), 255);
        cnt = 0;
        while (!done && cnt < 50) begin
            @(posedge tb_clk);
            #1;
            cnt++;
        end
        check("dz_next_q", 32'(q_out), 247);

        @(negedge tb_clk);
        divisor = 16'd22727;
        oscillator_out = 16'd22256;
        sample_now = 1'b1;
        @(posedge tb_clk);
        #1;
        sample_now = 1'b0;
        oscillator_out = 16'd100;
        repeat (5) @(posedge tb_clk);
        #1;
        check("q_hold_mid_calc", 32'(q_out), 247);
        cnt = 0;
        while (!done && cnt < 50) begin
            @(posedge tb_clk);
            #1;
            cnt++;
        end
        check("second_q", 32'(q_out), 250);
        check("second_q_round", 32'(q_out_r), 251);

        // Re-pulse sample_now during CALC is ignored
        @(negedge tb_clk);
        divisor = 16'd22727;
        oscillator_out = 16'd22000;
        sample_now = 1'b1;
        @(posedge tb_clk);
        #1;
        sample_now = 1'b0;
        repeat (2) @(posedge tb_clk);
        @(negedge tb_clk);
        divisor = 16'd3;
        oscillator_out = 16'd1;
        sample_now = 1'b1;
        @(posedge tb_clk);
        #1;
        sample_now = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge tb_clk);
            #1;
            if (done) begin
                cnt++;
                check("repulse_q", 32'(q_out), 247);
                check("repulse_q_round", 32'(q_out_r), 248);
            end
        end
        check("repulse_done_count", 32'(cnt), 1);

        // Reset in the middle of CALC aborts without a done pulse
        @(negedge tb_clk);
        divisor = 16'd22727;
        oscillator_out = 16'd22256;
        sample_now = 1'b1;
        @(posedge tb_clk);
        #1;
        sample_now = 1'b0;
        repeat (3) @(posedge tb_clk);
        @(negedge tb_clk);
        rst = 1'b1;
        @(posedge tb_clk);
        #1;
        check("abort_q", 32'(q_out), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        @(negedge tb_clk);
        rst = 1'b0;
        count_done(20, cnt);
        check("abort_no_done", 32'(cnt), 0);
        check("abort_q_held", 32'(q_out), 0);

        // sample_now held high: one result every Q_W+2 cycles
        @(negedge tb_clk);
        divisor = 16'd22727;
        oscillator_out = 16'd22000;
        sample_now = 1'b1;
        t0 = -1; t1 = -1; t2 = -1;
        for (cyc = 0; cyc < 60 && t2 < 0; cyc++) begin
            @(posedge tb_clk);
            #1;
            if (done) begin
                check("hold_q", 32'(q_out), 247);
                if (t0 < 0) t0 = cyc;
                else if (t1 < 0) t1 = cyc;
                else t2 = cyc;
            end
        end
        check("hold_first_latency", 32'(t0), 9);
        check("hold_period_1", 32'(t1 - t0), 10);
        check("hold_period_2", 32'(t2 - t1), 10);
        @(negedge tb_clk);
        sample_now = 1'b0;
        repeat (15) @(posedge tb_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
